// File: rtl/seg7_card_decoder_pkg.sv
// Shared card/segment definitions for the 7-seg encoder and decoder pair.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package seg7_card_decoder_pkg;

   typedef logic [3:0] card_t;

   // Active-high segment patterns {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_10    = 7'h3F;
   localparam logic [6:0] SEG_J     = 7'h1E;
   localparam logic [6:0] SEG_Q     = 7'h67;
   localparam logic [6:0] SEG_K     = 7'h76;

   typedef struct packed {
      logic [2:0] pos;
      card_t      card;
      logic       err;
   } card_evt_t;

   typedef struct packed {
      logic  err;
      card_t card;
   } dec_t;

   // Map an active-high pattern to a rank; anything unknown is flagged err with rank 0.
   function automatic dec_t seg2card(input logic [6:0] pat);
      dec_t r;
      r.err  = 1'b0;
      r.card = 4'd0;
      case (pat)
         SEG_BLANK: r.card = 4'd0;
         SEG_A:     r.card = 4'd1;
         SEG_2:     r.card = 4'd2;
         SEG_3:     r.card = 4'd3;
         SEG_4:     r.card = 4'd4;
         SEG_5:     r.card = 4'd5;
         SEG_6:     r.card = 4'd6;
         SEG_7:     r.card = 4'd7;
         SEG_8:     r.card = 4'd8;
         SEG_9:     r.card = 4'd9;
         SEG_10:    r.card = 4'd10;
         SEG_J:     r.card = 4'd11;
         SEG_Q:     r.card = 4'd12;
         SEG_K:     r.card = 4'd13;
         default:   r.err  = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_card_decoder_if.sv
// Display-bus sample input plus event/table outputs of the card decoder.
// Latency: n/a (wiring bundle).
// Backpressure: evt_valid/evt_ready handshake on the event side only.
interface seg7_card_decoder_if
   import seg7_card_decoder_pkg::*;
#(
   parameter int NUM_POS = 6
);
   logic                   seg_vld;
   logic [2:0]             seg_pos;
   logic [6:0]             seg_n;
   logic                   clr_sticky;
   logic                   evt_valid;
   logic                   evt_ready;
   logic [2:0]             evt_pos;
   card_t                  evt_card;
   logic                   evt_err;
   logic [4*NUM_POS-1:0]   cards;
   logic                   ovf;

   modport master (
      output seg_vld, seg_pos, seg_n, clr_sticky, evt_ready,
      input  evt_valid, evt_pos, evt_card, evt_err, cards, ovf
   );

   modport slave (
      input  seg_vld, seg_pos, seg_n, clr_sticky, evt_ready,
      output evt_valid, evt_pos, evt_card, evt_err, cards, ovf
   );
endinterface

// File: rtl/seg7_card_decoder_fifo.sv
// First-word-fall-through event queue carrying card_evt_t.
// Latency: pushed word visible on the output the cycle after the push when empty.
// Backpressure: pop_vld_o/pop_rdy_i; push while full is accepted only alongside a pop.
module seg_evt_fifo
   import seg7_card_decoder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push_vld_i,
   input  card_evt_t push_dat_i,
   output logic      pop_vld_o,
   input  logic      pop_rdy_i,
   output card_evt_t pop_dat_o,
   output logic      full_o
);
   localparam int AW = $clog2(DEPTH);

   card_evt_t      mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           empty;
   logic           pop;
   logic           push;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = !empty && pop_rdy_i;
   // When full, a simultaneous pop frees the slot the push lands in.
   assign push      = push_vld_i && (!full_o || pop);
   assign pop_vld_o = !empty;
   // Output held at zero when empty so stale entries never leak out.
   assign pop_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance on accepted push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   // Pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset because the output is gated by empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end
endmodule

// File: rtl/seg7_card_decoder.sv
// Stability-filters a multiplexed 7-seg bus, decodes to ranks, keeps a card table, queues changes.
// Latency: event on evt_* and table update one cycle after the committing sample (FIFO empty).
// Backpressure: evt_ready stalls the queue; a commit into a full queue without a pop is dropped, ovf set.
module seg7_card_decoder
   import seg7_card_decoder_pkg::*;
#(
   parameter int NUM_POS    = 6,
   parameter int STABLE_CNT = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   seg7_card_decoder_if.slave   bus
);
   localparam int CW = $clog2(STABLE_CNT + 1);

   logic [6:0]          last_pat_q [NUM_POS];
   logic [6:0]          last_pat_d [NUM_POS];
   logic [CW-1:0]       cnt_q      [NUM_POS];
   logic [CW-1:0]       cnt_d      [NUM_POS];
   card_t               cards_q    [NUM_POS];
   card_t               cards_d    [NUM_POS];
   logic                ovf_q, ovf_d;

   logic [6:0]          pat;
   logic                samp_ok;
   dec_t                dec;
   logic                commit;
   logic                push_vld;
   card_evt_t           push_dat;
   logic                fifo_vld;
   card_evt_t           fifo_dat;
   logic                fifo_full;
   logic                drop;
   logic [4*NUM_POS-1:0] cards_flat;

   assign pat     = ~bus.seg_n;
   assign samp_ok = bus.seg_vld && ({1'b0, bus.seg_pos} < 4'(NUM_POS));
   assign dec     = seg2card(pat);

   // Run-length filter per position, commit detection and table update
   always_comb begin
      for (int p = 0; p < NUM_POS; p++) begin
         last_pat_d[p] = last_pat_q[p];
         cnt_d[p]      = cnt_q[p];
         cards_d[p]    = cards_q[p];
      end
      commit   = 1'b0;
      push_vld = 1'b0;
      push_dat = '0;
      if (samp_ok) begin
         for (int p = 0; p < NUM_POS; p++) begin
            if (bus.seg_pos == 3'(p)) begin
               if (pat == last_pat_q[p]) begin
                  // Saturated runs hold their count and never re-commit
                  if (cnt_q[p] != CW'(STABLE_CNT)) begin
                     cnt_d[p] = cnt_q[p] + CW'(1);
                     commit   = ((cnt_q[p] + CW'(1)) == CW'(STABLE_CNT));
                  end
               end else begin
                  last_pat_d[p] = pat;
                  cnt_d[p]      = CW'(1);
                  commit        = (STABLE_CNT == 1);
               end
               if (commit) begin
                  if (dec.err) begin
                     push_vld     = 1'b1;
                     push_dat.pos = 3'(p);
                     push_dat.err = 1'b1;
                  end else if (dec.card != cards_q[p]) begin
                     cards_d[p]    = dec.card;
                     push_vld      = 1'b1;
                     push_dat.pos  = 3'(p);
                     push_dat.card = dec.card;
                  end
               end
            end
         end
      end
   end

   // Sticky overflow: a drop in the same cycle as clr_sticky keeps it set
   always_comb begin
      drop  = push_vld && fifo_full && !(fifo_vld && bus.evt_ready);
      ovf_d = ovf_q;
      if (bus.clr_sticky) ovf_d = 1'b0;
      if (drop)           ovf_d = 1'b1;
   end

   // Filter state, card table and ovf registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_POS; p++) begin
            last_pat_q[p] <= '0;
            cnt_q[p]      <= '0;
            cards_q[p]    <= '0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_POS; p++) begin
            last_pat_q[p] <= last_pat_d[p];
            cnt_q[p]      <= cnt_d[p];
            cards_q[p]    <= cards_d[p];
         end
         ovf_q <= ovf_d;
      end
   end

   // Flatten the card table onto the output bus
   always_comb begin
      cards_flat = '0;
      for (int p = 0; p < NUM_POS; p++) begin
         cards_flat[4*p +: 4] = cards_q[p];
      end
   end

   seg_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_vld_i (push_vld),
      .push_dat_i (push_dat),
      .pop_vld_o  (fifo_vld),
      .pop_rdy_i  (bus.evt_ready),
      .pop_dat_o  (fifo_dat),
      .full_o     (fifo_full)
   );

   assign bus.evt_valid = fifo_vld;
   assign bus.evt_pos   = fifo_dat.pos;
   assign bus.evt_card  = fifo_dat.card;
   assign bus.evt_err   = fifo_dat.err;
   assign bus.cards     = cards_flat;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seg7_card_decoder.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic.
// Latency: model mirrors one-cycle event/table visibility.
// Backpressure: random evt_ready and clr_sticky exercise overflow and drain.
module tb_seg7_card_decoder;
   import seg7_card_decoder_pkg::*;

   localparam int NUM_POS    = 6;
   localparam int STABLE_CNT = 3;
   localparam int FIFO_DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   seg7_card_decoder_if #(.NUM_POS(NUM_POS)) bus ();

   seg7_card_decoder #(
      .NUM_POS    (NUM_POS),
      .STABLE_CNT (STABLE_CNT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Rank r is displayed by rank_pat[r]; anything not in the table is illegal.
   logic [6:0] rank_pat [14] = '{7'h00, 7'h77, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                 7'h07, 7'h7F, 7'h6F, 7'h3F, 7'h1E, 7'h67, 7'h76};
   logic [6:0] m_run_pat [NUM_POS];
   int         m_run_len [NUM_POS];
   int         m_cards   [NUM_POS];
   logic [7:0] mq [$];
   bit         m_ovf;

   always @(posedge clk or posedge reset) begin : model
      int p;
      int rank;
      logic [6:0] spat;
      bit popped;
      bit have;
      logic [7:0] ev;
      if (reset) begin
         for (int i = 0; i < NUM_POS; i++) begin
            m_run_pat[i] = 7'h00;
            m_run_len[i] = 0;
            m_cards[i]   = 0;
         end
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         popped = (mq.size() != 0) && bus.evt_ready;
         have   = 1'b0;
         ev     = '0;
         if (bus.seg_vld && (int'(bus.seg_pos) < NUM_POS)) begin
            p    = int'(bus.seg_pos);
            spat = ~bus.seg_n;
            if (spat == m_run_pat[p]) m_run_len[p]++;
            else begin
               m_run_pat[p] = spat;
               m_run_len[p] = 1;
            end
            if (m_run_len[p] == STABLE_CNT) begin
               rank = -1;
               for (int r = 0; r < 14; r++) if (rank_pat[r] == spat) rank = r;
               if (rank < 0) begin
                  have = 1'b1;
                  ev   = {3'(p), 4'd0, 1'b1};
               end else if (rank != m_cards[p]) begin
                  m_cards[p] = rank;
                  have = 1'b1;
                  ev   = {3'(p), 4'(rank), 1'b0};
               end
            end
         end
         if (popped) void'(mq.pop_front());
         if (bus.clr_sticky) m_ovf = 1'b0;
         if (have) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(ev);
            else m_ovf = 1'b1;
         end
      end
   end

   // Compare DUT against the model on every falling edge
   always @(negedge clk) begin
      if (started) begin
         check("cmp_evt_valid", 32'(bus.evt_valid), 32'(mq.size() != 0));
         if (mq.size() != 0)
            check("cmp_evt_head", 32'({bus.evt_pos, bus.evt_card, bus.evt_err}), 32'(mq[0]));
         for (int p = 0; p < NUM_POS; p++)
            check("cmp_cards", 32'(bus.cards[4*p +: 4]), 32'(m_cards[p]));
         check("cmp_ovf", 32'(bus.ovf), 32'(m_ovf));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic samp(input bit v, input logic [2:0] pos, input logic [6:0] pat_hi, input int n);
      for (int i = 0; i < n; i++) begin
         bus.seg_vld = v;
         bus.seg_pos = pos;
         bus.seg_n   = ~pat_hi;
         @(posedge clk); #1;
      end
      bus.seg_vld = 1'b0;
   endtask

   task automatic pop1();
      bus.evt_ready = 1'b1;
      @(posedge clk); #1;
      bus.evt_ready = 1'b0;
   endtask

   task automatic check_head(input string name, input int pos, input int card, input bit err);
      check(name, 32'({bus.evt_valid, bus.evt_pos, bus.evt_card, bus.evt_err}),
            32'({1'b1, 3'(pos), 4'(card), err}));
   endtask

   logic [6:0] t4_pats [5] = '{7'h5B, 7'h66, 7'h6D, 7'h7D, 7'h07};
   int         t4_rank [4] = '{2, 4, 5, 6};

   initial begin
      logic [2:0] rpos;
      logic [6:0] rpat;
      bus.seg_vld    = 1'b0;
      bus.seg_pos    = 3'd0;
      bus.seg_n      = 7'h7F;
      bus.clr_sticky = 1'b0;
      bus.evt_ready  = 1'b0;
      #1 reset = 1'b1;
      started = 1'b1;
      #10;
      check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
      check("rst_evt_fields", 32'({bus.evt_pos, bus.evt_card, bus.evt_err}), 32'd0);
      check("rst_cards", 32'(bus.cards), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // 1: ace at position 2
      samp(1, 3'd2, 7'h77, 2);
      check("t1_no_early", 32'(bus.evt_valid), 32'd0);
      samp(1, 3'd2, 7'h77, 1);
      check("t1_cards", 32'(bus.cards[11:8]), 32'd1);
      check_head("t1_head", 2, 1, 0);
      pop1();
      check("t1_drained", 32'(bus.evt_valid), 32'd0);

      // 2: interrupted run, then one commit, then saturation
      samp(1, 3'd0, 7'h5B, 2);
      check("t2_no_commit", 32'({bus.evt_valid, bus.cards[3:0]}), 32'd0);
      samp(1, 3'd0, 7'h4F, 3);
      check_head("t2_head", 0, 3, 0);
      pop1();
      check("t2_one_event", 32'(bus.evt_valid), 32'd0);
      samp(1, 3'd0, 7'h4F, 10);
      check("t2_saturated", 32'(bus.evt_valid), 32'd0);
      check("t2_cards", 32'(bus.cards[3:0]), 32'd3);

      // 3: illegal pattern
      samp(1, 3'd4, 7'h49, 3);
      check_head("t3_head", 4, 0, 1);
      check("t3_cards", 32'(bus.cards[19:16]), 32'd0);
      pop1();

      // 4: overflow, sticky clear, ordered drain
      for (int i = 0; i < 5; i++) samp(1, 3'd1, t4_pats[i], 3);
      check("t4_ovf_set", 32'(bus.ovf), 32'd1);
      check("t4_cards", 32'(bus.cards[7:4]), 32'd7);
      bus.clr_sticky = 1'b1;
      @(posedge clk); #1;
      bus.clr_sticky = 1'b0;
      check("t4_ovf_clr", 32'(bus.ovf), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_head("t4_drain", 1, t4_rank[i], 0);
         pop1();
      end
      check("t4_empty", 32'(bus.evt_valid), 32'd0);

      // 5: push and pop on the same edge while full
      samp(1, 3'd3, 7'h7F, 3);
      samp(1, 3'd3, 7'h6F, 3);
      samp(1, 3'd3, 7'h3F, 3);
      samp(1, 3'd3, 7'h1E, 3);
      check_head("t5_full_head", 3, 8, 0);
      samp(1, 3'd3, 7'h67, 2);
      bus.evt_ready = 1'b1;
      samp(1, 3'd3, 7'h67, 1);
      bus.evt_ready = 1'b0;
      check("t5_no_ovf", 32'(bus.ovf), 32'd0);
      for (int i = 9; i <= 12; i++) begin
         check_head("t5_drain", 3, i, 0);
         pop1();
      end
      check("t5_empty", 32'(bus.evt_valid), 32'd0);

      // 6: asynchronous reset mid-run, then out-of-range positions
      samp(1, 3'd0, 7'h66, 3);
      samp(1, 3'd2, 7'h5B, 3);
      samp(1, 3'd5, 7'h77, 2);
      check("t6_queued", 32'(bus.evt_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_valid", 32'(bus.evt_valid), 32'd0);
      check("t6_rst_cards", 32'(bus.cards), 32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      samp(1, 3'd0, 7'h77, 3);
      check_head("t6_head", 0, 1, 0);
      samp(1, 3'd7, 7'h77, 3);
      samp(1, 3'd6, 7'h5B, 3);
      check("t6_ignored_cards", 32'(bus.cards), 32'h000001);
      check_head("t6_ignored_head", 0, 1, 0);
      pop1();

      // Randomized traffic against the model
      rpos = 3'd0;
      rpat = 7'h00;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) >= 7) begin
            rpos = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) != 0) rpat = rank_pat[$urandom_range(0, 13)];
            else rpat = 7'($urandom);
         end
         bus.seg_vld    = ($urandom_range(0, 9) != 0);
         bus.seg_pos    = rpos;
         bus.seg_n      = ~rpat;
         bus.evt_ready  = ($urandom_range(0, 3) == 0);
         bus.clr_sticky = ($urandom_range(0, 31) == 0);
         if (c == 2000) begin
            reset = 1'b1;
            @(negedge clk); reset = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.seg_vld    = 1'b0;
      bus.clr_sticky = 1'b0;
      bus.evt_ready  = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      check("final_drained", 32'(bus.evt_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
